// File: rtl/jt1942_vrom_pkg.sv
// Shared types and constants for the 1942 video ROM arbiter.
// Slot indices, FSM states and default SDRAM word offsets.
package jt1942_vrom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_REQ2,
    ST_WAIT2
  } state_e;

  localparam logic [1:0] CHAR = 2'd0;
  localparam logic [1:0] SCR  = 2'd1;
  localparam logic [1:0] OBJ  = 2'd2;

  localparam logic [21:0] DEF_CHAR_OFFSET = 22'h00000;
  localparam logic [21:0] DEF_SCR_OFFSET  = 22'h08000;
  localparam logic [21:0] DEF_OBJ_OFFSET  = 22'h10000;

endpackage

// File: rtl/jt1942_vrom_slot.sv
// Single-entry last-address cache for one video ROM requester.
// ok is combinational so it drops the cycle the address moves.
module jt1942_vrom_slot
  import jt1942_vrom_pkg::*;
#(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  input  logic              wr,
  input  logic [AWIDTH-1:0] wr_tag,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [DWIDTH-1:0] data,
  output logic              ok,
  output logic              pending
);

  logic              valid_q, valid_d;
  logic [AWIDTH-1:0] tag_q, tag_d;
  logic [DWIDTH-1:0] data_q, data_d;

  // Hit detection against the live requester address
  always_comb begin
    ok      = valid_q && (tag_q == addr);
    pending = !ok;
    data    = data_q;
  end

  // Fill the entry when the arbiter completes a fetch for this slot
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr) begin
      valid_d = 1'b1;
      tag_d   = wr_tag;
      data_d  = wr_data;
    end
  end

  // Cache registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/jt1942_vrom_arb.sv
// Round-robin SDRAM read arbiter for char, scroll and obj ROMs.
// Scroll pixels need two 16-bit words; the first is staged here.
module jt1942_vrom_arb
  import jt1942_vrom_pkg::*;
#(
  parameter int            AW          = 22,
  parameter logic [AW-1:0] CHAR_OFFSET = AW'(DEF_CHAR_OFFSET),
  parameter logic [AW-1:0] SCR_OFFSET  = AW'(DEF_SCR_OFFSET),
  parameter logic [AW-1:0] OBJ_OFFSET  = AW'(DEF_OBJ_OFFSET)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   char_addr,
  output logic [15:0]   char_data,
  output logic          char_ok,
  input  logic [13:0]   scr_addr,
  output logic [23:0]   scr_data,
  output logic          scr_ok,
  input  logic [14:0]   obj_addr,
  output logic [15:0]   obj_data,
  output logic          obj_ok,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [15:0]   sdram_din
);

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    gsel_q, gsel_d;
  logic [14:0]   gaddr_q, gaddr_d;
  logic [15:0]   stage_q, stage_d;
  logic [AW-1:0] sdram_addr_q, sdram_addr_d;
  logic          sdram_req_q, sdram_req_d;

  logic [2:0]    pend;
  logic [2:0]    wr;
  logic [1:0]    gnt_sel;
  logic          gnt_any;
  logic [AW-1:0] char_wa, obj_wa, scr_w0, scr_w1;
  logic          word1_done, word2_done;

  jt1942_vrom_slot #(.AWIDTH(12), .DWIDTH(16)) u_char (
    .clk     (clk),
    .rst     (rst),
    .addr    (char_addr),
    .wr      (wr[CHAR]),
    .wr_tag  (gaddr_q[11:0]),
    .wr_data (sdram_din),
    .data    (char_data),
    .ok      (char_ok),
    .pending (pend[CHAR])
  );

  jt1942_vrom_slot #(.AWIDTH(14), .DWIDTH(24)) u_scr (
    .clk     (clk),
    .rst     (rst),
    .addr    (scr_addr),
    .wr      (wr[SCR]),
    .wr_tag  (gaddr_q[13:0]),
    .wr_data ({sdram_din[7:0], stage_q}),
    .data    (scr_data),
    .ok      (scr_ok),
    .pending (pend[SCR])
  );

  jt1942_vrom_slot #(.AWIDTH(15), .DWIDTH(16)) u_obj (
    .clk     (clk),
    .rst     (rst),
    .addr    (obj_addr),
    .wr      (wr[OBJ]),
    .wr_tag  (gaddr_q),
    .wr_data (sdram_din),
    .data    (obj_data),
    .ok      (obj_ok),
    .pending (pend[OBJ])
  );

  assign sdram_addr = sdram_addr_q;
  assign sdram_req  = sdram_req_q;

  // SDRAM word addresses; word1 uses the latched grant address
  always_comb begin
    char_wa = CHAR_OFFSET + AW'(char_addr);
    obj_wa  = OBJ_OFFSET + AW'(obj_addr);
    scr_w0  = SCR_OFFSET + AW'({scr_addr, 1'b0});
    scr_w1  = SCR_OFFSET + AW'({gaddr_q[13:0], 1'b1});
  end

  // Round-robin pick, starting after the last granted slot
  always_comb begin
    gnt_any = |pend;
    gnt_sel = ptr_q;
    unique case (ptr_q)
      SCR: gnt_sel = pend[OBJ]  ? OBJ  : pend[CHAR] ? CHAR : SCR;
      OBJ: gnt_sel = pend[CHAR] ? CHAR : pend[SCR]  ? SCR  : OBJ;
      default: gnt_sel = pend[SCR] ? SCR : pend[OBJ] ? OBJ : CHAR;
    endcase
  end

  // Data arrival for the first and second word, ack+rdy merged
  always_comb begin
    word1_done = data_rdy && ((state_q == ST_WAIT) ||
                 (state_q == ST_REQ && sdram_ack));
    word2_done = data_rdy && ((state_q == ST_WAIT2) ||
                 (state_q == ST_REQ2 && sdram_ack));
  end

  // Fetch sequencing: grant, handshake, fill or stage scroll word
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gsel_d       = gsel_q;
    gaddr_d      = gaddr_q;
    stage_d      = stage_q;
    sdram_addr_d = sdram_addr_q;
    sdram_req_d  = sdram_req_q;
    wr           = 3'b000;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          gsel_d      = gnt_sel;
          ptr_d       = gnt_sel;
          sdram_req_d = 1'b1;
          state_d     = ST_REQ;
          unique case (gnt_sel)
            CHAR: begin
              gaddr_d      = 15'(char_addr);
              sdram_addr_d = char_wa;
            end
            SCR: begin
              gaddr_d      = 15'(scr_addr);
              sdram_addr_d = scr_w0;
            end
            default: begin
              gaddr_d      = obj_addr;
              sdram_addr_d = obj_wa;
            end
          endcase
        end
      end
      ST_REQ, ST_WAIT: begin
        if (state_q == ST_REQ && sdram_ack) begin
          sdram_req_d = 1'b0;
          state_d     = ST_WAIT;
        end
        if (word1_done) begin
          if (gsel_q == SCR) begin
            stage_d      = sdram_din;
            sdram_addr_d = scr_w1;
            sdram_req_d  = 1'b1;
            state_d      = ST_REQ2;
          end else begin
            wr[gsel_q] = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_REQ2, ST_WAIT2: begin
        if (state_q == ST_REQ2 && sdram_ack) begin
          sdram_req_d = 1'b0;
          state_d     = ST_WAIT2;
        end
        if (word2_done) begin
          wr[SCR] = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and arbiter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= CHAR;
      gsel_q       <= CHAR;
      gaddr_q      <= '0;
      stage_q      <= '0;
      sdram_addr_q <= '0;
      sdram_req_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gsel_q       <= gsel_d;
      gaddr_q      <= gaddr_d;
      stage_q      <= stage_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_req_q  <= sdram_req_d;
    end
  end

endmodule

// File: tb/tb_jt1942_vrom_arb.sv
// Directed bench for the video ROM arbiter.
// Acts as the SDRAM controller and checks each step in line.
module tb_jt1942_vrom_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] char_addr = '0;
  logic [15:0] char_data;
  logic        char_ok;
  logic [13:0] scr_addr = '0;
  logic [23:0] scr_data;
  logic        scr_ok;
  logic [14:0] obj_addr = '0;
  logic [15:0] obj_data;
  logic        obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        ack = 1'b0;
  logic        rdy = 1'b0;
  logic [15:0] din = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jt1942_vrom_arb dut (
    .clk        (clk),
    .rst        (rst),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .char_ok    (char_ok),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_ok     (scr_ok),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (ack),
    .data_rdy   (rdy),
    .sdram_din  (din)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input logic [21:0] a);
    for (int i = 0; i < 30 && sdram_req !== 1'b1; i++) tick();
    chk({tag, "_req"}, 32'(sdram_req), 32'd1);
    chk({tag, "_addr"}, 32'(sdram_addr), 32'(a));
  endtask

  task automatic do_ack();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_rdy(input logic [15:0] d);
    tick();
    rdy = 1'b1;
    din = d;
    tick();
    rdy = 1'b0;
  endtask

  task automatic serve(input string tag, input logic [21:0] a,
                       input logic [15:0] d);
    wait_req(tag, a);
    do_ack();
    do_rdy(d);
  endtask

  initial begin
    // reset state
    tick(); tick(); tick();
    chk("rst_char_ok", 32'(char_ok), 0);
    chk("rst_scr_ok", 32'(scr_ok), 0);
    chk("rst_obj_ok", 32'(obj_ok), 0);
    chk("rst_req", 32'(sdram_req), 0);
    chk("rst_addr", 32'(sdram_addr), 0);
    chk("rst_scr_data", 32'(scr_data), 0);
    rst = 1'b0;

    // address 0 everywhere is a miss; pointer=char so scr goes first
    serve("fill_scr0", 22'h08000, 16'h0001);
    chk("fill_scr_mid_ok", 32'(scr_ok), 0);
    serve("fill_scr1", 22'h08001, 16'h0002);
    chk("fill_scr_data", 32'(scr_data), 32'h020001);
    serve("fill_obj", 22'h10000, 16'h0003);
    serve("fill_char", 22'h00000, 16'h0004);
    chk("fill_char_ok", 32'(char_ok), 1);
    chk("fill_obj_data", 32'(obj_data), 32'h0003);

    // single char fetch, latency and hold
    char_addr = 12'h123;
    #1;
    chk("t1_ok_drop", 32'(char_ok), 0);
    tick();
    chk("t1_req_lat", 32'(sdram_req), 1);
    chk("t1_addr", 32'(sdram_addr), 32'h00123);
    do_ack();
    do_rdy(16'h5A5A);
    chk("t1_ok", 32'(char_ok), 1);
    chk("t1_data", 32'(char_data), 32'h5A5A);
    repeat (5) tick();
    chk("t1_no_rereq", 32'(sdram_req), 0);

    // round-robin order with all three pending after an obj grant
    obj_addr = 15'h0020;
    serve("t2_obj0", 22'h10020, 16'h0303);
    char_addr = 12'h200;
    scr_addr  = 14'h0010;
    obj_addr  = 15'h0030;
    serve("t2_char", 22'h00200, 16'h0404);
    serve("t2_scr0", 22'h08020, 16'h1111);
    serve("t2_scr1", 22'h08021, 16'h0022);
    serve("t2_obj", 22'h10030, 16'h0505);
    chk("t2_char_data", 32'(char_data), 32'h0404);
    chk("t2_scr_data", 32'(scr_data), 32'h221111);
    chk("t2_obj_data", 32'(obj_data), 32'h0505);
    chk("t2_all_ok", 32'({char_ok, scr_ok, obj_ok}), 32'b111);

    // two-word scroll fetch
    scr_addr = 14'h0005;
    serve("t3_w0", 22'h0800A, 16'hBEEF);
    chk("t3_mid_ok", 32'(scr_ok), 0);
    serve("t3_w1", 22'h0800B, 16'h12AB);
    chk("t3_data", 32'(scr_data), 32'hABBEEF);
    chk("t3_ok", 32'(scr_ok), 1);

    // obj address moves during WAIT
    obj_addr = 15'h0010;
    wait_req("t4_a", 22'h10010);
    do_ack();
    obj_addr = 15'h0011;
    do_rdy(16'h7777);
    chk("t4_ok_stale", 32'(obj_ok), 0);
    chk("t4_data_stale", 32'(obj_data), 32'h7777);
    wait_req("t4_b", 22'h10011);
    do_ack();
    do_rdy(16'h8888);
    chk("t4_ok", 32'(obj_ok), 1);
    chk("t4_data", 32'(obj_data), 32'h8888);

    // ack and data in the same REQ cycle, then stray data in IDLE
    char_addr = 12'h0AB;
    wait_req("t5", 22'h000AB);
    ack = 1'b1;
    rdy = 1'b1;
    din = 16'hC0DE;
    tick();
    ack = 1'b0;
    rdy = 1'b0;
    chk("t5_ok", 32'(char_ok), 1);
    chk("t5_data", 32'(char_data), 32'hC0DE);
    chk("t5_req", 32'(sdram_req), 0);
    rdy = 1'b1;
    din = 16'hFFFF;
    tick();
    rdy = 1'b0;
    chk("t5_stray_data", 32'(char_data), 32'hC0DE);
    chk("t5_stray_req", 32'(sdram_req), 0);

    // reset in WAIT2 abandons the scroll fetch
    scr_addr = 14'h0007;
    serve("t6_w0", 22'h0800E, 16'h1234);
    wait_req("t6_w1", 22'h0800F);
    do_ack();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_oks", 32'({char_ok, scr_ok, obj_ok}), 0);
    chk("t6_req", 32'(sdram_req), 0);
    chk("t6_addr", 32'(sdram_addr), 0);
    rdy = 1'b1;
    din = 16'h5555;
    tick();
    rdy = 1'b0;
    chk("t6_restart_req", 32'(sdram_req), 1);
    chk("t6_restart_addr", 32'(sdram_addr), 32'h0800E);
    chk("t6_scr_data", 32'(scr_data), 0);
    do_ack();
    do_rdy(16'hAAAA);
    serve("t6_w1b", 22'h0800F, 16'h00BB);
    chk("t6_scr_final", 32'(scr_data), 32'hBBAAAA);
    serve("t6_obj", 22'h10011, 16'h0101);
    serve("t6_char", 22'h000AB, 16'h0202);
    chk("t6_all_ok", 32'({char_ok, scr_ok, obj_ok}), 32'b111);
    chk("t6_char_data", 32'(char_data), 32'h0202);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jt1942_vrom_arb.md
Name: jt1942_vrom_arb

Overview:
- Shares the single SDRAM read port between the three video ROM requesters: char, scroll and obj.
- Each requester has its own last-address/data cache, so repeated addresses cost no SDRAM cycles.
- Scroll pixels are 24 bits wide and are fetched as two 16-bit words.
- Sits between the video block's ROM address/data ports and the SDRAM controller.

Parameters:
AW, 22, SDRAM word address width
CHAR_OFFSET, 22'h00000, SDRAM word base of char ROM
SCR_OFFSET, 22'h08000, SDRAM word base of scroll ROM
OBJ_OFFSET, 22'h10000, SDRAM word base of obj ROM

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
char_addr  in  12  char ROM address
char_data  out  16  cached char word
char_ok  out  1  char_data valid for current char_addr
scr_addr  in  14  scroll ROM address
scr_data  out  24  cached scroll pixel data
scr_ok  out  1  scr_data valid for current scr_addr
obj_addr  in  15  obj ROM address
obj_data  out  16  cached obj word
obj_ok  out  1  obj_data valid for current obj_addr
sdram_addr  out  AW  word address to SDRAM controller
sdram_req  out  1  read request; held until acked
sdram_ack  in  1  controller accepted sdram_addr
data_rdy  in  1  sdram_din valid this cycle
sdram_din  in  16  read data

Behaviour:
- Reset (rst=1 at a clock edge):
  - All caches invalid; all *_data = 0; all *_ok = 0.
  - sdram_req = 0, sdram_addr = 0; FSM = IDLE; round-robin pointer = char.
  - A reset during a fetch abandons it; a later data_rdy for that fetch is ignored.
- Per slot (char, scr, obj): registers valid, tag (address) and data.
  - pending = !valid || tag != current input addr.
  - *_ok = valid && tag == addr, computed combinationally, so it drops in the same cycle the address changes.
- Address mapping:
  - char: CHAR_OFFSET + char_addr.
  - obj: OBJ_OFFSET + obj_addr.
  - scr: word0 at SCR_OFFSET + {scr_addr,1'b0}, giving bits [15:0]; word1 at SCR_OFFSET + {scr_addr,1'b1}, whose low byte gives bits [23:16].
  - Additions are zero-extended to AW and wrap modulo 2^AW.
- Arbitration is round-robin among pending slots, in order char -> scr -> obj, starting after the last granted slot.
- FSM states: IDLE, REQ, WAIT, REQ2, WAIT2.
  - IDLE: if any slot is pending, grant it. At this edge latch gaddr = its input address, drive sdram_addr, set sdram_req = 1, go to REQ. The pointer advances to the grantee.
  - REQ: hold sdram_req and sdram_addr until sdram_ack. On ack, drop sdram_req and go to WAIT. If ack and data_rdy coincide, treat as ack followed by immediate data.
  - WAIT: on data_rdy, store sdram_din.
    - char/obj: data <= sdram_din, tag <= gaddr, valid <= 1, go to IDLE.
    - scr: store sdram_din into data[15:0] staging, go to REQ2 with the word1 address.
  - REQ2 / WAIT2: same handshake as REQ / WAIT. On data_rdy: scr_data <= {din[7:0], staged word}, tag <= gaddr, valid <= 1, go to IDLE.
- The cache is written with the address latched at grant (gaddr), not the live input. If the input changed mid-fetch, the slot is pending again afterwards and ok stays 0.
- Latency, no contention:
  - sdram_req rises 1 cycle after the address change.
  - ok rises 1 cycle after the final data_rdy edge.
  - IDLE costs one cycle between fetches.
- data_rdy outside WAIT/WAIT2/REQ-with-ack is ignored.
- sdram_ack is ignored while sdram_req = 0.

Decomposition:
- Package jt1942_vrom_pkg holds:
  - FSM state enum.
  - Slot index constants CHAR=0, SCR=1, OBJ=2.
  - Default offset constants.
- Sub-module jt1942_vrom_slot: parameterised AWIDTH/DWIDTH. Contains the tag/data/valid registers, the pending compare and the ok logic. Instantiated 3 times.
- The top level holds the FSM, the round-robin pointer and the scroll word staging.

Test Plan:
- Reset, then char_addr=12'h123 with ack/rdy each 2 cycles later -> sdram_addr=22'h00123; char_data=din; char_ok=1; no second request while the address is held.
- All three slots pending at once -> grant order char, scr, obj. With obj pending continuously, char and scr are still served within one rotation.
- scr_addr=14'h0005 -> two requests at 22'h0800A then 22'h0800B. Din 16'hBEEF then 16'h12AB gives scr_data=24'hABBEEF; scr_ok rises once, after the second word.
- obj_addr changes from 15'h10 to 15'h11 during WAIT -> the cache stores tag 15'h10 and obj_ok stays 0; a new fetch at 22'h10011 follows automatically.
- sdram_ack and data_rdy high in the same REQ cycle -> fetch completes and the FSM is in IDLE on the next cycle; a stray data_rdy in IDLE changes nothing.
- rst asserted in WAIT2 -> all ok=0, sdram_req=0; a later data_rdy is ignored, and the pending scroll fetch restarts from word0.
